// File: rtl/alu_pkg.sv
// Shared definitions for the ALU accumulator slice: default widths, ALU op-codes
// and the accumulator state enumeration.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned LEN_W_DEF = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_PASA = 3'd5,
        OP_PASB = 3'd6,
        OP_NOP  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } accum_state_e;

endpackage : alu_pkg

// File: rtl/alu_beat_cnt.sv
// Beat down-counter for an accumulation run; a zero length field loads 2^LEN_W.
module alu_beat_cnt
    import alu_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             dec_i,
    output logic             last_o
);

    localparam logic [LEN_W:0] ONE      = {{LEN_W{1'b0}}, 1'b1};
    localparam logic [LEN_W:0] FULL_LEN = {1'b1, {LEN_W{1'b0}}};

    logic [LEN_W:0] count_q;
    logic [LEN_W:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = (len_i == '0) ? FULL_LEN : {1'b0, len_i};
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == ONE);

endmodule : alu_beat_cnt

// File: rtl/alu_accum.sv
// Accumulates a fixed-length run of upstream ALU results, with sticky carry-out
// detection and a valid/ready handshake for the completed total.
module alu_accum
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_sum,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] runsum,
    output logic             overflow,
    output logic             busy
);

    accum_state_e     state_q;
    logic [WIDTH-1:0] runsum_q;
    logic             overflow_q;

    logic [WIDTH:0]   sum_d;
    logic             accept;
    logic             cnt_load;
    logic             cnt_last;

    // Carry-out lands in the extra top bit of the widened sum.
    assign sum_d    = {1'b0, runsum_q} + {1'b0, in_sum};
    assign accept   = (state_q == ST_ACCUM) && in_valid;
    assign cnt_load = (state_q == ST_IDLE) && start;

    alu_beat_cnt #(
        .LEN_W (LEN_W)
    ) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .len_i  (len),
        .dec_i  (accept),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            runsum_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_ACCUM;
                        runsum_q   <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        runsum_q   <= sum_d[WIDTH-1:0];
                        overflow_q <= overflow_q | sum_d[WIDTH];
                        if (cnt_last) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Handshake flags depend on the state register alone.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign runsum    = runsum_q;
    assign overflow  = overflow_q;

endmodule : alu_accum

// File: tb/tb_alu_accum.sv
// Self-checking bench for alu_accum: table-driven runs, directed corner cases
// and randomized runs checked against a plain-arithmetic reference.
module tb_alu_accum;

    localparam int unsigned W  = 16;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LW-1:0] len;
    logic          in_valid;
    logic [W-1:0]  in_sum;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  runsum;
    logic          overflow;
    logic          busy;

    always #5 clk = ~clk;

    alu_accum #(
        .WIDTH (W),
        .LEN_W (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .runsum    (runsum),
        .overflow  (overflow),
        .busy      (busy)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] beats [16];

    typedef struct {
        logic [3:0]  lenf;
        logic [15:0] base;
        logic [15:0] step;
        int          hold;
        bit          noise;
        logic [15:0] exp_sum;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [6];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run: start, beats (with optional stalls), DONE hold, exit.
    // gap>0 forces that many idle cycles before every beat after the first.
    task automatic do_run(input logic [3:0] lenf, input int gap, input int rand_stall,
                          input int hold, input bit noise, input bit start_at_exit,
                          output logic [15:0] fsum, output logic fovf);
        int     n;
        longint acc;
        n   = (lenf == 4'd0) ? 16 : int'(lenf);
        acc = 0;
        start = 1'b1; len = lenf; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        start = 1'b0;
        check1("start_in_ready", in_ready, 1'b1);
        check1("start_busy", busy, 1'b1);
        check16("start_runsum_clr", runsum, 16'h0000);
        check1("start_ovf_clr", overflow, 1'b0);
        for (int k = 0; k < n; k++) begin
            int st;
            if (gap > 0) st = (k > 0) ? gap : 0;
            else         st = (rand_stall > 0) ? int'($urandom_range(rand_stall, 0)) : 0;
            for (int s = 0; s < st; s++) begin
                in_valid = 1'b0;
                in_sum   = 16'($urandom);
                start    = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                len      = 4'($urandom);
                tick();
                check16("stall_hold_sum", runsum, acc[15:0]);
                check1("stall_in_ready", in_ready, 1'b1);
                check1("stall_out_valid", out_valid, 1'b0);
            end
            in_valid = 1'b1;
            in_sum   = beats[k];
            start    = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            len      = 4'($urandom);
            tick();
            in_valid = 1'b0;
            start    = 1'b0;
            acc += longint'(beats[k]);
            check16("beat_runsum", runsum, acc[15:0]);
            check1("beat_ovf", overflow, acc >= 65536);
            check1("beat_out_valid", out_valid, k == n - 1);
            check1("beat_in_ready", in_ready, k != n - 1);
        end
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = noise ? 1'($urandom_range(1, 0)) : 1'b0;
            tick();
            check1("done_valid_held", out_valid, 1'b1);
            check1("done_in_ready", in_ready, 1'b0);
            check16("done_sum_stable", runsum, acc[15:0]);
            check1("done_ovf_stable", overflow, acc >= 65536);
        end
        out_ready = 1'b1;
        start     = start_at_exit;
        len       = 4'd1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check1("exit_out_valid", out_valid, 1'b0);
        check1("exit_busy", busy, 1'b0);
        check16("exit_sum_kept", runsum, acc[15:0]);
        tick();
        check1("idle_no_restart", busy, 1'b0);
        check1("idle_in_ready", in_ready, 1'b0);
        check16("idle_sum_kept", runsum, acc[15:0]);
        check1("idle_ovf_kept", overflow, acc >= 65536);
        fsum = runsum;
        fovf = overflow;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] fsum;
        logic        fovf;

        tbl[0] = '{4'd3,  16'h0001, 16'h0001, 0, 1'b0, 16'h0006, 1'b0};
        tbl[1] = '{4'd2,  16'hFFFF, 16'h0003, 2, 1'b0, 16'h0001, 1'b1};
        tbl[2] = '{4'd0,  16'h0001, 16'h0000, 1, 1'b1, 16'h0010, 1'b0};
        tbl[3] = '{4'd1,  16'h1234, 16'h0000, 0, 1'b0, 16'h1234, 1'b0};
        tbl[4] = '{4'd4,  16'h4000, 16'h0000, 1, 1'b1, 16'h0000, 1'b1};
        tbl[5] = '{4'd15, 16'h0000, 16'h0001, 0, 1'b0, 16'h0069, 1'b0};

        rst = 1'b1; start = 1'b0; len = 4'd0; in_valid = 1'b0;
        in_sum = 16'h0000; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check1("rst_busy", busy, 1'b0);
        check1("rst_in_ready", in_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check16("rst_runsum", runsum, 16'h0000);
        check1("rst_overflow", overflow, 1'b0);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 16; k++) beats[k] = tbl[i].base + 16'(k) * tbl[i].step;
            do_run(tbl[i].lenf, 0, 0, tbl[i].hold, tbl[i].noise, 1'b0, fsum, fovf);
            check16("tbl_final_sum", fsum, tbl[i].exp_sum);
            check1("tbl_final_ovf", fovf, tbl[i].exp_ovf);
        end

        // Stalls between beats and a held-off consumer.
        beats[0] = 16'h0010; beats[1] = 16'h0020;
        do_run(4'd2, 5, 0, 4, 1'b0, 1'b0, fsum, fovf);
        check16("stall_run_sum", fsum, 16'h0030);

        // start together with out_ready in DONE must not open a new run.
        beats[0] = 16'h0777;
        do_run(4'd1, 0, 0, 1, 1'b0, 1'b1, fsum, fovf);
        check16("exit_start_sum", fsum, 16'h0777);

        // Reset mid-run discards the partial sum and beats rst-coincident inputs.
        start = 1'b1; len = 4'd4; tick(); start = 1'b0;
        in_valid = 1'b1; in_sum = 16'h0100; tick();
        in_sum = 16'h0200; tick();
        check16("midrun_partial", runsum, 16'h0300);
        rst = 1'b1; start = 1'b1; in_sum = 16'h0055; out_ready = 1'b1; tick();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check1("midrun_rst_busy", busy, 1'b0);
        check1("midrun_rst_in_ready", in_ready, 1'b0);
        check16("midrun_rst_sum", runsum, 16'h0000);
        tick();
        check1("midrun_rst_no_start", busy, 1'b0);
        beats[0] = 16'h0005;
        do_run(4'd1, 0, 0, 0, 1'b0, 1'b0, fsum, fovf);
        check16("post_rst_sum", fsum, 16'h0005);

        // Reset in DONE clears a set overflow flag.
        start = 1'b1; len = 4'd2; tick(); start = 1'b0;
        in_valid = 1'b1; in_sum = 16'h8000; tick(); tick();
        in_valid = 1'b0;
        check1("done_pre_rst_valid", out_valid, 1'b1);
        check1("done_pre_rst_ovf", overflow, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        check1("done_rst_valid", out_valid, 1'b0);
        check1("done_rst_ovf", overflow, 1'b0);
        check16("done_rst_sum", runsum, 16'h0000);

        // Randomized runs against the arithmetic reference inside do_run.
        for (int r = 0; r < 40; r++) begin
            logic [3:0] lf;
            lf = 4'($urandom);
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(3, 0) == 0) beats[k] = 16'($urandom_range(65535, 60000));
                else                           beats[k] = 16'($urandom_range(4095, 0));
            end
            do_run(lf, 0, 3, int'($urandom_range(3, 0)), 1'b1, 1'($urandom_range(1, 0)), fsum, fovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_accum
